// File: rtl/norm32_seq.sv
// Iterative 32-bit normalizer: shifts an operand left until bit 31 is set and
// reports the shift amount (CLZ). One shift step per clock, valid/ready on both sides.
module norm32_seq #(
    parameter int unsigned BYTE_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_shamt,
    output logic        out_zero
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] val;
    logic [5:0]  cnt;
    logic        val_zero;
    logic        val_norm;
    logic        byte_ok;

    assign val_zero = (val == '0);
    assign val_norm = val[31];
    // A byte step only fires with the top byte clear, so it can never push a set bit past 31.
    assign byte_ok  = (BYTE_STEP != 0) && (val[31:24] == 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (val_zero || val_norm) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_shamt <= '0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        val <= in_data;
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    if (val_zero) begin
                        out_zero  <= 1'b1;
                        out_data  <= '0;
                        out_shamt <= 6'd32;
                    end else if (val_norm) begin
                        out_zero  <= 1'b0;
                        out_data  <= val;
                        out_shamt <= cnt;
                    end else if (byte_ok) begin
                        val <= val << 8;
                        cnt <= cnt + 6'd8;
                    end else begin
                        val <= val << 1;
                        cnt <= cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_norm32_seq.sv
// Bench for norm32_seq: two instances (byte stepping on and off) exercised with
// directed cases and random operands against a CLZ-based reference model.
module tb_norm32_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_data   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data  [2];
    logic [5:0]  out_shamt [2];
    logic        out_zero  [2];

    int vectors;
    int errors;

    norm32_seq #(.BYTE_STEP(1)) dut_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0]),
        .out_shamt (out_shamt[0]),
        .out_zero  (out_zero[0])
    );

    norm32_seq #(.BYTE_STEP(0)) dut_bit (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1]),
        .out_shamt (out_shamt[1]),
        .out_zero  (out_zero[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clz(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return 31 - i;
        end
        return 32;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input int d, input string tag);
        check({tag, " in_ready"},  32'(in_ready[d]),  32'd1);
        check({tag, " out_valid"}, 32'(out_valid[d]), 32'd0);
        check({tag, " out_data"},  out_data[d],       32'd0);
        check({tag, " out_shamt"}, 32'(out_shamt[d]), 32'd0);
        check({tag, " out_zero"},  32'(out_zero[d]),  32'd0);
    endtask

    // d=0: byte stepping, d=1: single-bit only
    task automatic run_op(input int d, input logic [31:0] op, input int stall, input string tag);
        int          n;
        int          steps;
        int          lat;
        logic [31:0] exp_data;
        logic [31:0] exp_shamt;
        logic [31:0] exp_zero;
        n         = clz(op);
        steps     = (op == 0) ? 0 : ((d == 0) ? (n / 8 + n % 8) : n);
        exp_data  = (op == 0) ? 32'd0 : (op << n);
        exp_shamt = 32'(n);
        exp_zero  = (op == 0) ? 32'd1 : 32'd0;

        @(negedge clk);
        check({tag, " ready before"}, 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b1;
        in_data[d]  = op;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_data[d]  = $urandom;
        lat = 0;
        while (!out_valid[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"},   32'(lat),          32'(steps + 1));
        check({tag, " out_data"},  out_data[d],       exp_data);
        check({tag, " out_shamt"}, 32'(out_shamt[d]), exp_shamt);
        check({tag, " out_zero"},  32'(out_zero[d]),  exp_zero);

        // Stall with a spurious new operand offered; it must be ignored.
        for (int s = 0; s < stall; s++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = $urandom;
            @(posedge clk);
            #1;
            check({tag, " stall valid"}, 32'(out_valid[d]), 32'd1);
            check({tag, " stall ready"}, 32'(in_ready[d]),  32'd0);
            check({tag, " stall data"},  out_data[d],       exp_data);
            check({tag, " stall shamt"}, 32'(out_shamt[d]), exp_shamt);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        check({tag, " idle valid"}, 32'(out_valid[d]), 32'd0);
        check({tag, " idle ready"}, 32'(in_ready[d]),  32'd1);
        check({tag, " held data"},  out_data[d],       exp_data);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] ones;
        ones = '1;
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'd1 << $urandom_range(0, 31);
            2:       return ones >> $urandom_range(0, 32);
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    initial begin
        int seen;
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            out_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(0, "reset0");
        check_reset_outputs(1, "reset1");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 32'h8000_0000, 0, "norm_b");
        run_op(1, 32'h8000_0000, 0, "norm_s");
        run_op(0, 32'h0000_0001, 1, "worst_b");
        run_op(1, 32'h0000_0001, 1, "worst_s");
        run_op(0, 32'h0000_0000, 0, "zero_b");
        run_op(1, 32'h0000_0000, 2, "zero_s");
        run_op(0, 32'h0001_2345, 10, "bp_b");
        run_op(0, 32'hFFFF_FFFF, 0, "ones_b");
        run_op(0, 32'h00FF_FFFF, 0, "byte_edge");

        // Abort an operation with reset: outputs clear at once and nothing emerges later.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h0000_0001;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0, "midreset");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (out_valid[0] || !in_ready[0]) seen++;
        end
        check("midreset no output", 32'(seen), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            run_op(0, rand_operand(), $urandom_range(0, 3), "rand_b");
        end
        for (int i = 0; i < 800; i++) begin
            run_op(1, rand_operand(), $urandom_range(0, 3), "rand_s");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
